palindrome_stream_checker: RTL
==============================

Name: palindrome_stream_checker

Overview:
Sequential, parametrised successor to the team's combinational 3-bit palindrome detector. Accepts a framed stream of SYM_W-bit symbols over a valid/ready handshake and buffers up to DEPTH symbols. At frame end it compares mirrored symbol pairs, one pair per cycle, and reports whether the frame is a palindrome. Intended as a checker stage on serial test-pattern and packet paths.

Parameters:
SYM_W, 1, symbol width in bits (>=1)
DEPTH, 16, maximum stored symbols per frame (>=2)
CNT_W, $clog2(DEPTH+1), localparam; width of length and pointer fields

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  input symbol valid
in_ready  out  1  checker can accept a symbol
in_data  in  SYM_W  input symbol
in_last  in  1  qualifies the final symbol of a frame
res_valid  out  1  one-cycle result strobe
res_pal  out  1  frame is a palindrome (meaningful when res_valid=1)
res_len  out  CNT_W  stored symbol count of the reported frame
res_ovf  out  1  frame exceeded DEPTH symbols

Behaviour:
- Interface (decided): one clock, clk; reset rst is asynchronous and active-high.
- Reset clears all state immediately: state=FILL, count=0, ovf=0, mis=0, in_ready=1, res_valid=0, res_pal=0, res_len=0, res_ovf=0. A partial frame or an in-flight check is discarded. The buffer contents are not reset.
- FSM states: FILL, CHECK, DONE.
- FILL: in_ready=1. A symbol is accepted when in_valid && in_ready.
  - If count<DEPTH: buf[count]<=in_data and count increments.
  - Otherwise: the symbol is dropped and ovf is set.
  - Accepted with in_last=1: if ovf is set, or is being set this cycle, go to DONE. Otherwise go to CHECK with lo=0, hi=count_new-1, mis=0.
- CHECK: in_ready=0. Each cycle:
  - if lo>=hi, go to DONE without comparing;
  - else if buf[lo]!=buf[hi], set mis and go to DONE;
  - else lo++, hi--, and stay in CHECK.
  - A palindrome of length L therefore spends floor(L/2)+1 cycles in CHECK. A mismatch at pair k (0-based) spends k+1 cycles.
- DONE: lasts exactly one cycle, with in_ready=0 and all result outputs registered.
  - res_valid=1
  - res_pal = !mis && !ovf
  - res_len = count (saturates at DEPTH)
  - res_ovf = ovf
  - Next state is FILL, with count, ovf and mis cleared.
- Outside DONE, res_valid=0. res_pal, res_len and res_ovf hold their last values.
- in_valid while in_ready=0 is ignored. The upstream must hold the symbol until it is accepted.
- A frame always contains at least one symbol, so count>=1 on entry to CHECK.
- in_data is never inspected when it has not been accepted.

Optional Feature:
PAL_STATS_EN
- When defined, adds outputs stat_frames[15:0] and stat_pals[15:0].
  - Both reset to 0 and wrap modulo 2^16.
  - stat_frames increments on every DONE cycle.
  - stat_pals increments on DONE when res_pal=1.
- When undefined, these ports and counters do not exist. All other behaviour is identical.

Decomposition:
- Package pal_pkg: state enum (FILL, CHECK, DONE) and a typedef for the result bundle {pal, ovf, len}.
- Sub-module pal_buffer: DEPTH x SYM_W register file with one write port and two combinational read ports (lo, hi). The checker FSM owns the count, pointers and flags.

Test Plan:
- SYM_W=1, DEPTH=16: frame 1,0,1 (in_last on the third symbol) -> 2 CHECK cycles, then res_valid=1, res_pal=1, res_len=3, res_ovf=0. in_ready=0 for 3 cycles.
- SYM_W=1: frame 1,1,0 -> mismatch on the first compare, 1 CHECK cycle, then res_pal=0, res_len=3.
- SYM_W=1: single symbol 0 with in_last -> 1 CHECK cycle, res_pal=1, res_len=1. Back-to-back frames 0,0 then 1,0 -> results pal=1 then pal=0.
- DEPTH=16: 17 symbols of 0, in_last on the 17th -> CHECK is skipped, res_valid on the next cycle, res_ovf=1, res_pal=0, res_len=16. The following frame reports res_ovf=0.
- SYM_W=8: frame 0x41,0x42,0x42,0x41 -> res_pal=1, res_len=4. Frame 0x41,0x42,0x43,0x41 -> res_pal=0 after 2 CHECK cycles.
- Assert rst mid-CHECK (async, between edges) -> in_ready=1 and res_valid=0 immediately. The next frame 1,0,1 yields res_pal=1, res_len=3. With PAL_STATS_EN, the counters read 0 after the reset.

Source files
------------

// File: rtl/pal_pkg.sv
// Shared types for the palindrome stream checker: FSM states and the result bundle.
package pal_pkg;
  typedef enum logic [1:0] {FILL, CHECK, DONE} state_t;

  localparam int RES_LEN_W = 16;

  typedef struct packed {
    logic                 pal;
    logic                 ovf;
    logic [RES_LEN_W-1:0] len;
  } result_t;
endpackage

// File: rtl/pal_buffer.sv
// Symbol store: one synchronous write port, two combinational read ports (lo/hi mirror pair).
module pal_buffer
  import pal_pkg::*;
#(
  parameter  int SYM_W = 1,
  parameter  int DEPTH = 16,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [SYM_W-1:0] wr_data,
  input  logic [AW-1:0]    lo_addr,
  input  logic [AW-1:0]    hi_addr,
  output logic [SYM_W-1:0] lo_data,
  output logic [SYM_W-1:0] hi_data
);
  logic [SYM_W-1:0] r_mem [DEPTH];

  // Contents are deliberately not reset; only positions below count are ever read.
  always_ff @(posedge clk) begin
    if (wr_en) r_mem[wr_addr] <= wr_data;
  end

  assign lo_data = r_mem[lo_addr];
  assign hi_data = r_mem[hi_addr];
endmodule

// File: rtl/palindrome_stream_checker.sv
// Framed-stream palindrome checker: buffer a frame, then compare mirrored pairs one per cycle.
// Optional PAL_STATS_EN adds stat_frames / stat_pals counters.
module palindrome_stream_checker
  import pal_pkg::*;
#(
  parameter  int SYM_W = 1,
  parameter  int DEPTH = 16,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SYM_W-1:0] in_data,
  input  logic             in_last,
  output logic             res_valid,
  output logic             res_pal,
  output logic [CNT_W-1:0] res_len,
  output logic             res_ovf
`ifdef PAL_STATS_EN
  ,
  output logic [15:0]      stat_frames,
  output logic [15:0]      stat_pals
`endif
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  state_t           r_state;
  logic [CNT_W-1:0] r_count, r_lo, r_hi;
  logic             r_ovf, r_mis, r_in_ready, r_res_valid;
  result_t          r_res;

  logic             w_accept, w_room, w_wr_en, w_ovf_new;
  logic [CNT_W-1:0] w_count_new;
  logic [SYM_W-1:0] w_lo_data, w_hi_data;

`ifdef PAL_STATS_EN
  logic [15:0] r_stat_frames, r_stat_pals;
`endif

  assign w_accept    = in_valid && r_in_ready;
  assign w_room      = (r_count < DEPTH_C);
  assign w_wr_en     = w_accept && w_room;
  assign w_ovf_new   = r_ovf || (w_accept && !w_room);
  assign w_count_new = w_wr_en ? (r_count + ONE) : r_count;

  pal_buffer #(.SYM_W(SYM_W), .DEPTH(DEPTH)) u_buf (
    .clk     (clk),
    .wr_en   (w_wr_en),
    .wr_addr (r_count[AW-1:0]),
    .wr_data (in_data),
    .lo_addr (r_lo[AW-1:0]),
    .hi_addr (r_hi[AW-1:0]),
    .lo_data (w_lo_data),
    .hi_data (w_hi_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= FILL;
      r_count     <= '0;
      r_lo        <= '0;
      r_hi        <= '0;
      r_ovf       <= 1'b0;
      r_mis       <= 1'b0;
      r_in_ready  <= 1'b1;
      r_res_valid <= 1'b0;
      r_res       <= '0;
`ifdef PAL_STATS_EN
      r_stat_frames <= '0;
      r_stat_pals   <= '0;
`endif
    end else begin
      r_res_valid <= 1'b0;
      case (r_state)
        FILL: begin
          if (w_accept) begin
            r_count <= w_count_new;
            r_ovf   <= w_ovf_new;
            if (in_last) begin
              r_in_ready <= 1'b0;
              // An overflowed frame can never be a palindrome, so the compare phase is skipped.
              if (w_ovf_new) begin
                r_state     <= DONE;
                r_res_valid <= 1'b1;
                r_res       <= '{pal: 1'b0, ovf: 1'b1, len: RES_LEN_W'(w_count_new)};
              end else begin
                r_state <= CHECK;
                r_lo    <= '0;
                r_hi    <= w_count_new - ONE;
                r_mis   <= 1'b0;
              end
            end
          end
        end
        CHECK: begin
          if (r_lo >= r_hi) begin
            r_state     <= DONE;
            r_res_valid <= 1'b1;
            r_res       <= '{pal: !r_mis && !r_ovf, ovf: r_ovf, len: RES_LEN_W'(r_count)};
          end else if (w_lo_data != w_hi_data) begin
            r_mis       <= 1'b1;
            r_state     <= DONE;
            r_res_valid <= 1'b1;
            r_res       <= '{pal: 1'b0, ovf: r_ovf, len: RES_LEN_W'(r_count)};
          end else begin
            r_lo <= r_lo + ONE;
            r_hi <= r_hi - ONE;
          end
        end
        DONE: begin
          r_state    <= FILL;
          r_in_ready <= 1'b1;
          r_count    <= '0;
          r_ovf      <= 1'b0;
          r_mis      <= 1'b0;
`ifdef PAL_STATS_EN
          r_stat_frames <= r_stat_frames + 16'd1;
          if (r_res.pal) r_stat_pals <= r_stat_pals + 16'd1;
`endif
        end
        default: r_state <= FILL;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign res_valid = r_res_valid;
  assign res_pal   = r_res.pal;
  assign res_ovf   = r_res.ovf;
  assign res_len   = CNT_W'(r_res.len);

`ifdef PAL_STATS_EN
  assign stat_frames = r_stat_frames;
  assign stat_pals   = r_stat_pals;
`endif
endmodule
